// File: rtl/alu_pkg.sv
// ALU control codes, RV32I opcodes and the decoded-instruction bundle
// shared by the ID-stage decoder, the ID/EX register and the ALU.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0110;
    localparam logic [3:0] ALU_SRL  = 4'b0111;
    localparam logic [3:0] ALU_BLT  = 4'b1000;
    localparam logic [3:0] ALU_BGE  = 4'b1001;
    localparam logic [3:0] ALU_BLTU = 4'b1010;
    localparam logic [3:0] ALU_BGEU = 4'b1011;
    localparam logic [3:0] ALU_BEQ  = 4'b1100;
    localparam logic [3:0] ALU_BNE  = 4'b1101;
    localparam logic [3:0] ALU_SRA  = 4'b1110;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_00 = 7'h00;
    localparam logic [6:0] F7_20 = 7'h20;

    typedef struct packed {
        logic [3:0]  alu_ctrl;
        logic        use_imm;
        logic [31:0] imm;
        logic        reg_write;
        logic        is_branch;
        logic        illegal;
    } dec_t;

    // Base funct3 map shared by OP and OP-IMM (funct7 = 00 flavour).
    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        logic [3:0] c;
        c = ALU_ADD;
        unique case (f3)
            3'b000: c = ALU_ADD;
            3'b001: c = ALU_SLL;
            3'b010: c = ALU_SLT;
            3'b011: c = ALU_SLTU;
            3'b100: c = ALU_XOR;
            3'b101: c = ALU_SRL;
            3'b110: c = ALU_OR;
            3'b111: c = ALU_AND;
            default: c = ALU_ADD;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_ctrl_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the ID stage.
// master: the decode stage; slave: the fetch/execute environment.
interface alu_ctrl_decode_stage_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic            if_valid;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    logic            id_ready;
    logic            flush;
    logic            ex_ready;
    logic            ex_valid;
    logic [3:0]      ex_alu_ctrl;
    logic            ex_use_imm;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rs1;
    logic [4:0]      ex_rs2;
    logic [4:0]      ex_rd;
    logic            ex_reg_write;
    logic            ex_is_branch;
    logic            ex_illegal;
    logic [XLEN-1:0] ex_pc;
    logic [CNT_W-1:0] illegal_cnt;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        input  if_valid, if_instr, if_pc, flush, ex_ready,
        output id_ready, ex_valid, ex_alu_ctrl, ex_use_imm, ex_imm,
        output ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_is_branch,
        output ex_illegal, ex_pc, illegal_cnt, stall_cnt
    );

    modport slave (
        output if_valid, if_instr, if_pc, flush, ex_ready,
        input  id_ready, ex_valid, ex_alu_ctrl, ex_use_imm, ex_imm,
        input  ex_rs1, ex_rs2, ex_rd, ex_reg_write, ex_is_branch,
        input  ex_illegal, ex_pc, illegal_cnt, stall_cnt
    );

endinterface

// File: rtl/alu_ctrl_decoder.sv
// Combinational RV32I decoder: instr_i -> ALU code, immediate and flags.
// Ports: instr_i (instruction word), dec_o (decoded bundle).
module alu_ctrl_decoder
    import alu_pkg::*;
(
    input  logic [31:0] instr_i,
    output dec_t        dec_o
);

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_sh;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];
    assign rd  = instr_i[11:7];

    assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
    assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
    assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
    assign imm_u  = {instr_i[31:12], 12'b0};
    assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
    assign imm_sh = {27'b0, instr_i[24:20]};

    always_comb begin
        dec_o          = '0;
        dec_o.alu_ctrl = ALU_ADD;
        unique case (1'b1)
            (opc == OPC_OP): begin
                dec_o.reg_write = 1'b1;
                dec_o.alu_ctrl  = f3_alu(f3);
                if (f7 == F7_20 && f3 == 3'b000) begin
                    dec_o.alu_ctrl = ALU_SUB;
                end else if (f7 == F7_20 && f3 == 3'b101) begin
                    dec_o.alu_ctrl = ALU_SRA;
                end else if (f7 != F7_00) begin
                    dec_o.illegal = 1'b1;
                end
            end
            (opc == OPC_OPIMM): begin
                dec_o.use_imm   = 1'b1;
                dec_o.reg_write = 1'b1;
                dec_o.alu_ctrl  = f3_alu(f3);
                dec_o.imm       = imm_i;
                // Shifts reuse imm[11:5] as a funct7-style qualifier.
                if (f3 == 3'b001 || f3 == 3'b101) begin
                    dec_o.imm = imm_sh;
                    if (f3 == 3'b101 && f7 == F7_20) begin
                        dec_o.alu_ctrl = ALU_SRA;
                    end else if (f7 != F7_00) begin
                        dec_o.illegal = 1'b1;
                    end
                end
            end
            (opc == OPC_BRANCH): begin
                dec_o.is_branch = 1'b1;
                dec_o.imm       = imm_b;
                case (f3)
                    3'b000:  dec_o.alu_ctrl = ALU_BEQ;
                    3'b001:  dec_o.alu_ctrl = ALU_BNE;
                    3'b100:  dec_o.alu_ctrl = ALU_BLT;
                    3'b101:  dec_o.alu_ctrl = ALU_BGE;
                    3'b110:  dec_o.alu_ctrl = ALU_BLTU;
                    3'b111:  dec_o.alu_ctrl = ALU_BGEU;
                    default: dec_o.illegal  = 1'b1;
                endcase
            end
            (opc == OPC_LOAD): begin
                dec_o.use_imm   = 1'b1;
                dec_o.reg_write = 1'b1;
                dec_o.imm       = imm_i;
            end
            (opc == OPC_STORE): begin
                dec_o.use_imm = 1'b1;
                dec_o.imm     = imm_s;
            end
            (opc == OPC_LUI),
            (opc == OPC_AUIPC): begin
                dec_o.use_imm   = 1'b1;
                dec_o.reg_write = 1'b1;
                dec_o.imm       = imm_u;
            end
            (opc == OPC_JAL): begin
                dec_o.use_imm   = 1'b1;
                dec_o.reg_write = 1'b1;
                dec_o.imm       = imm_j;
            end
            (opc == OPC_JALR): begin
                dec_o.use_imm   = 1'b1;
                dec_o.reg_write = 1'b1;
                dec_o.imm       = imm_i;
                dec_o.illegal   = (f3 != 3'b000);
            end
            default: begin
                dec_o.illegal = 1'b1;
            end
        endcase

        // Illegal ops travel as a harmless ADD with no side effects.
        if (dec_o.illegal) begin
            dec_o         = '0;
            dec_o.illegal = 1'b1;
        end
        if (rd == 5'd0) begin
            dec_o.reg_write = 1'b0;
        end
    end

endmodule

// File: rtl/alu_ctrl_decode_stage.sv
// ID stage: decodes if_instr and holds the result in the ID/EX register.
// Ports: clk, rst_n (async, active low), bus (handshake + ex_* + counters).
module alu_ctrl_decode_stage
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    alu_ctrl_decode_stage_if.master bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    dec_t dec;

    logic             load;
    logic             valid_d;
    logic             valid_q;
    logic [3:0]       alu_q;
    logic             use_imm_q;
    logic [XLEN-1:0]  imm_q;
    logic [4:0]       rs1_q;
    logic [4:0]       rs2_q;
    logic [4:0]       rd_q;
    logic             rw_q;
    logic             br_q;
    logic             ill_q;
    logic [XLEN-1:0]  pc_q;
    logic [CNT_W-1:0] ill_cnt_d;
    logic [CNT_W-1:0] ill_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q;

    alu_ctrl_decoder u_dec (
        .instr_i (bus.if_instr),
        .dec_o   (dec)
    );

    assign bus.id_ready = !valid_q || bus.ex_ready;
    assign load = bus.if_valid && bus.id_ready && !bus.flush;

    always_comb begin
        valid_d     = valid_q;
        ill_cnt_d   = ill_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (bus.flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
        end else if (bus.ex_ready) begin
            valid_d = 1'b0;
        end
        if (load && dec.illegal && ill_cnt_q != CNT_MAX) begin
            ill_cnt_d = ill_cnt_q + CNT_ONE;
        end
        if (valid_q && !bus.ex_ready && !bus.flush &&
            stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            alu_q       <= '0;
            use_imm_q   <= 1'b0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rw_q        <= 1'b0;
            br_q        <= 1'b0;
            ill_q       <= 1'b0;
            pc_q        <= '0;
            ill_cnt_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            ill_cnt_q   <= ill_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            // Payload only moves on a load; a flush leaves it frozen.
            if (load) begin
                alu_q     <= dec.alu_ctrl;
                use_imm_q <= dec.use_imm;
                imm_q     <= dec.imm;
                rs1_q     <= bus.if_instr[19:15];
                rs2_q     <= bus.if_instr[24:20];
                rd_q      <= bus.if_instr[11:7];
                rw_q      <= dec.reg_write;
                br_q      <= dec.is_branch;
                ill_q     <= dec.illegal;
                pc_q      <= bus.if_pc;
            end
        end
    end

    assign bus.ex_valid     = valid_q;
    assign bus.ex_alu_ctrl  = alu_q;
    assign bus.ex_use_imm   = use_imm_q;
    assign bus.ex_imm       = imm_q;
    assign bus.ex_rs1       = rs1_q;
    assign bus.ex_rs2       = rs2_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_reg_write = rw_q;
    assign bus.ex_is_branch = br_q;
    assign bus.ex_illegal   = ill_q;
    assign bus.ex_pc        = pc_q;
    assign bus.illegal_cnt  = ill_cnt_q;
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Bench for alu_ctrl_decode_stage: directed cases plus random traffic
// against a table-driven decode model and a transaction-level pipe model.
module tb_alu_ctrl_decode_stage;

    localparam int XLEN  = 32;
    localparam int CNT_W = 16;
    localparam int CMAX  = 65535;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    alu_ctrl_decode_stage_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

    alu_ctrl_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  alu;
        bit          ui;
        logic [31:0] imm;
        bit          rw;
        bit          br;
        bit          ill;
    } ref_t;

    localparam logic [3:0] F3MAP [8] =
        '{4'h0, 4'h6, 4'h5, 4'hF, 4'h4, 4'h7, 4'h3, 4'h2};
    localparam logic [3:0] BMAP [8] =
        '{4'hC, 4'hD, 4'h0, 4'h0, 4'h8, 4'h9, 4'hA, 4'hB};
    localparam logic [6:0] OPS [9] =
        '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67};

    int n_tests = 0;
    int n_fail  = 0;

    bit          m_valid;
    ref_t        m_dec;
    logic [31:0] m_instr;
    logic [31:0] m_pc;
    int          m_ill;
    int          m_stall;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic ref_t ref_dec(logic [31:0] w);
        ref_t        r;
        logic [31:0] sg;
        logic [31:0] ii;
        logic [2:0]  f3;
        logic [6:0]  f7;
        sg = {32{w[31]}};
        ii = $signed(w) >>> 20;
        f3 = w[14:12];
        f7 = w[31:25];
        r.alu = 4'h0; r.ui = 0; r.imm = 32'h0;
        r.rw = 0; r.br = 0; r.ill = 0;
        case (w[6:0])
            7'h33: begin
                r.rw = 1;
                if (f7 == 7'h00) r.alu = F3MAP[f3];
                else if (f7 == 7'h20 && f3 == 3'd0) r.alu = 4'h1;
                else if (f7 == 7'h20 && f3 == 3'd5) r.alu = 4'hE;
                else r.ill = 1;
            end
            7'h13: begin
                r.ui = 1; r.rw = 1; r.alu = F3MAP[f3]; r.imm = ii;
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    r.imm = 32'(w[24:20]);
                    if (f3 == 3'd5 && f7 == 7'h20) r.alu = 4'hE;
                    else if (f7 != 7'h00) r.ill = 1;
                end
            end
            7'h63: begin
                r.br = 1; r.alu = BMAP[f3];
                r.ill = (f3 == 3'd2 || f3 == 3'd3);
                r.imm = (sg << 12) | (32'(w[7]) << 11) |
                        (32'(w[30:25]) << 5) | (32'(w[11:8]) << 1);
            end
            7'h03: begin r.ui = 1; r.rw = 1; r.imm = ii; end
            7'h67: begin
                r.ui = 1; r.rw = 1; r.imm = ii; r.ill = (f3 != 3'd0);
            end
            7'h23: begin
                r.ui = 1; r.imm = (ii & ~32'h1F) | 32'(w[11:7]);
            end
            7'h37, 7'h17: begin
                r.ui = 1; r.rw = 1; r.imm = w & 32'hFFFFF000;
            end
            7'h6F: begin
                r.ui = 1; r.rw = 1;
                r.imm = (sg << 20) | (32'(w[19:12]) << 12) |
                        (32'(w[20]) << 11) | (32'(w[30:21]) << 1);
            end
            default: r.ill = 1;
        endcase
        if (r.ill) begin r.alu = 4'h0; r.rw = 0; r.br = 0; end
        if (w[11:7] == 5'd0) r.rw = 0;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) w[6:0] = OPS[k];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    task automatic drive(bit v, logic [31:0] ins, bit er, bit fl);
        bus.if_valid  = v;
        bus.if_instr  = ins;
        bus.if_pc     = $urandom;
        bus.if_pc[1:0] = 2'b00;
        bus.ex_ready  = er;
        bus.flush     = fl;
    endtask

    task automatic model_edge();
        bit load;
        load = bus.if_valid && (!m_valid || bus.ex_ready) && !bus.flush;
        if (m_valid && !bus.ex_ready && !bus.flush && m_stall < CMAX)
            m_stall++;
        if (bus.flush) begin
            m_valid = 0;
        end else if (load) begin
            m_valid = 1;
            m_instr = bus.if_instr;
            m_pc    = bus.if_pc;
            m_dec   = ref_dec(bus.if_instr);
            if (m_dec.ill && m_ill < CMAX) m_ill++;
        end else if (bus.ex_ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare();
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_valid));
        chk("illegal_cnt", 32'(bus.illegal_cnt), m_ill);
        chk("stall_cnt", 32'(bus.stall_cnt), m_stall);
        if (m_valid) begin
            chk("alu_ctrl", 32'(bus.ex_alu_ctrl), 32'(m_dec.alu));
            chk("illegal", 32'(bus.ex_illegal), 32'(m_dec.ill));
            chk("reg_write", 32'(bus.ex_reg_write), 32'(m_dec.rw));
            chk("is_branch", 32'(bus.ex_is_branch), 32'(m_dec.br));
            chk("rs1", 32'(bus.ex_rs1), 32'(m_instr[19:15]));
            chk("rs2", 32'(bus.ex_rs2), 32'(m_instr[24:20]));
            chk("rd", 32'(bus.ex_rd), 32'(m_instr[11:7]));
            chk("pc", bus.ex_pc, m_pc);
            if (!m_dec.ill) begin
                chk("use_imm", 32'(bus.ex_use_imm), 32'(m_dec.ui));
                chk("imm", bus.ex_imm, m_dec.imm);
            end
        end
    endtask

    task automatic step(input bit do_chk);
        @(negedge clk);
        if (do_chk)
            chk("id_ready", 32'(bus.id_ready),
                32'(!m_valid || bus.ex_ready));
        @(posedge clk);
        model_edge();
        #1;
        if (do_chk) compare();
    endtask

    task automatic chk_reset(string tag);
        chk({tag, "_valid"}, 32'(bus.ex_valid), 32'h0);
        chk({tag, "_ready"}, 32'(bus.id_ready), 32'h1);
        chk({tag, "_alu"}, 32'(bus.ex_alu_ctrl), 32'h0);
        chk({tag, "_imm"}, bus.ex_imm, 32'h0);
        chk({tag, "_useimm"}, 32'(bus.ex_use_imm), 32'h0);
        chk({tag, "_regs"},
            32'({bus.ex_rs1, bus.ex_rs2, bus.ex_rd}), 32'h0);
        chk({tag, "_flags"}, 32'({bus.ex_reg_write, bus.ex_is_branch,
                                  bus.ex_illegal}), 32'h0);
        chk({tag, "_pc"}, bus.ex_pc, 32'h0);
        chk({tag, "_illcnt"}, 32'(bus.illegal_cnt), 32'h0);
        chk({tag, "_stallcnt"}, 32'(bus.stall_cnt), 32'h0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int guard;
        m_valid = 0; m_ill = 0; m_stall = 0;
        m_instr = 32'h0; m_pc = 32'h0; m_dec = ref_dec(32'h0);
        drive(0, 32'h0, 1, 0);
        #12;
        chk_reset("rst0");
        rst_n = 1'b1;

        drive(1, 32'h40B50533, 1, 0); step(1);
        chk("sub_alu", 32'(bus.ex_alu_ctrl), 32'h1);
        chk("sub_useimm", 32'(bus.ex_use_imm), 32'h0);
        chk("sub_rd", 32'(bus.ex_rd), 32'd10);
        chk("sub_rw", 32'(bus.ex_reg_write), 32'h1);

        drive(1, 32'h4035D593, 1, 0); step(1);
        chk("srai_alu", 32'(bus.ex_alu_ctrl), 32'hE);
        chk("srai_useimm", 32'(bus.ex_use_imm), 32'h1);
        chk("srai_imm", bus.ex_imm, 32'h3);

        drive(1, 32'hFFF00513, 1, 0); step(1);
        chk("addi_alu", 32'(bus.ex_alu_ctrl), 32'h0);
        chk("addi_imm", bus.ex_imm, 32'hFFFFFFFF);

        drive(1, 32'hFE0718E3, 1, 0); step(1);
        chk("bne_alu", 32'(bus.ex_alu_ctrl), 32'hD);
        chk("bne_br", 32'(bus.ex_is_branch), 32'h1);
        chk("bne_rw", 32'(bus.ex_reg_write), 32'h0);
        chk("bne_imm", bus.ex_imm, 32'hFFFFFFF0);

        drive(1, 32'h00100093, 1, 0); step(1);
        drive(1, 32'h00208113, 0, 0);
        repeat (5) begin
            step(1);
            chk("stall_rd", 32'(bus.ex_rd), 32'd1);
        end
        chk("stall5", 32'(bus.stall_cnt), 32'd5);
        drive(1, 32'h00208113, 1, 0); step(1);
        chk("release_rd", 32'(bus.ex_rd), 32'd2);
        chk("release_valid", 32'(bus.ex_valid), 32'h1);

        drive(1, 32'h00300193, 1, 1); step(1);
        chk("flush_valid", 32'(bus.ex_valid), 32'h0);

        drive(1, 32'h00000000, 1, 0); step(1);
        chk("ill0_flag", 32'(bus.ex_illegal), 32'h1);
        chk("ill0_rw", 32'(bus.ex_reg_write), 32'h0);
        chk("ill0_cnt", 32'(bus.illegal_cnt), 32'h1);
        drive(0, 32'h0, 1, 0); step(1);

        repeat (3000) begin
            drive($urandom_range(0, 3) != 0, rand_instr(),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            step(1);
        end

        drive(1, 32'h00000000, 1, 0);
        guard = 0;
        while (m_ill < CMAX && guard < 70000) begin
            step(0);
            guard++;
        end
        chk("sat_reach", 32'(bus.illegal_cnt), 32'hFFFF);
        step(1);
        step(1);
        chk("sat_hold", 32'(bus.illegal_cnt), 32'hFFFF);

        drive(1, 32'h40B50533, 1, 0); step(1);
        drive(1, 32'h00100093, 0, 0); step(1);
        chk("pre_rst_valid", 32'(bus.ex_valid), 32'h1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset("rst1");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
